program_loader: RTL and testbench

//  Boot-time initiator for the core's memory load ports (IMLD/IMWD/IMA, DMLD/DMWD/DMA).

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Command, byte-stream and memory-load signals between the boot loader and its
// host/memories. master = loader side, slave = host/memory side.
interface program_loader_if;
  logic        start;
  logic        target;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        IMLD;
  logic [31:0] IMWD;
  logic [31:0] IMA;
  logic        DMLD;
  logic [31:0] DMWD;
  logic [31:0] DMA;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, target, base_addr, word_count, byte_valid, byte_data,
    output byte_ready, IMLD, IMWD, IMA, DMLD, DMWD, DMA, core_rst, busy, done, error
  );

  modport slave (
    output start, target, base_addr, word_count, byte_valid, byte_data,
    input  byte_ready, IMLD, IMWD, IMA, DMLD, DMWD, DMA, core_rst, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them
// to instruction or data memory, holding the core in reset until the image is in.
module program_loader #(
  parameter int DEPTH = 64,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus
);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  localparam logic [31:0] STEP_W  = 32'(STEP);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  typedef struct packed {
    logic        tgt;
    logic [31:0] addr;
    logic [15:0] remaining;
  } cmd_t;

  state_t      state, state_nx;
  cmd_t        cmd;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;
  logic        accept, bad_count;

  logic        byte_ready, busy, done, error, core_rst;
  logic        im_ld, dm_ld;
  logic [31:0] im_wd, im_a, dm_wd, dm_a;
  logic        byte_ready_nx, busy_nx, done_nx, im_ld_nx, dm_ld_nx;

  assign accept    = (state == RECV) && bus.byte_valid;
  assign bad_count = (bus.word_count == 16'd0) || (bus.word_count > DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && !bad_count) state_nx = RECV;
      RECV:    if (accept && byte_idx == 2'd3) state_nx = WRITE;
      WRITE:   state_nx = (cmd.remaining == 16'd1) ? DONE : RECV;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    byte_ready_nx = (state_nx == RECV);
    busy_nx       = (state_nx == RECV) || (state_nx == WRITE);
    done_nx       = (state_nx == DONE);
    im_ld_nx      = (state_nx == WRITE) && !cmd.tgt;
    dm_ld_nx      = (state_nx == WRITE) &&  cmd.tgt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= '0;
      byte_idx   <= 2'd0;
      word_lo    <= 24'd0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      im_ld      <= 1'b0;
      dm_ld      <= 1'b0;
      im_wd      <= 32'd0;
      im_a       <= 32'd0;
      dm_wd      <= 32'd0;
      dm_a       <= 32'd0;
      error      <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      byte_ready <= byte_ready_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      im_ld      <= im_ld_nx;
      dm_ld      <= dm_ld_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_count) begin
              error <= 1'b1;
            end else begin
              cmd.tgt       <= bus.target;
              cmd.addr      <= bus.base_addr;
              cmd.remaining <= bus.word_count;
              byte_idx      <= 2'd0;
              error         <= 1'b0;
              core_rst      <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= bus.byte_data;
              2'd1: word_lo[15:8]  <= bus.byte_data;
              2'd2: word_lo[23:16] <= bus.byte_data;
              default: begin
                // Only the selected port's data/address move; the other holds.
                if (cmd.tgt) begin
                  dm_wd <= {bus.byte_data, word_lo};
                  dm_a  <= cmd.addr;
                end else begin
                  im_wd <= {bus.byte_data, word_lo};
                  im_a  <= cmd.addr;
                end
              end
            endcase
          end
        end
        WRITE: begin
          cmd.addr      <= cmd.addr + STEP_W;
          cmd.remaining <= cmd.remaining - 16'd1;
          byte_idx      <= 2'd0;
        end
        DONE: core_rst <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.core_rst   = core_rst;
  assign bus.IMLD       = im_ld;
  assign bus.IMWD       = im_wd;
  assign bus.IMA        = im_a;
  assign bus.DMLD       = dm_ld;
  assign bus.DMWD       = dm_wd;
  assign bus.DMA        = dm_a;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized images, each load
// compared against an address/word list computed from the byte image.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if bus();
  program_loader #(.DEPTH(64), .STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;

  int   vectors = 0, miscompares = 0;
  wr_t  im_q[$], dm_q[$], exp_q[$];
  logic [7:0] img[$];
  int   done_cnt = 0, viol = 0, ready_viol = 0;
  bit   prev_ld = 1'b0;

  // Observe strobes and protocol rules away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    if (bus.IMLD) begin w.a = bus.IMA; w.d = bus.IMWD; im_q.push_back(w); end
    if (bus.DMLD) begin w.a = bus.DMA; w.d = bus.DMWD; dm_q.push_back(w); end
    if ((bus.IMLD || bus.DMLD) && prev_ld) viol++;
    if (bus.IMLD && bus.DMLD) viol++;
    prev_ld = bus.IMLD || bus.DMLD;
    if (bus.done) done_cnt++;
    if (bus.busy && !bus.IMLD && !bus.DMLD && !bus.byte_ready) ready_viol++;
  end

  function automatic void build_exp(input logic [31:0] base, input int cnt);
    wr_t w;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      w.a = base + 32'(4 * i);
      w.d = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      exp_q.push_back(w);
    end
  endfunction

  task automatic do_start(input logic t, input logic [31:0] b, input logic [15:0] c);
    bus.start = 1'b1; bus.target = t; bus.base_addr = b; bus.word_count = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap, input bit rnd);
    int n, g;
    for (int i = lo; i < hi; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = img[i];
      n = 0;
      @(negedge clk);
      while (!bus.byte_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        vectors++; miscompares++;
        $display("FAIL byte_accept_timeout byte=%0d ready=%b required=1", i, bus.byte_ready);
        bus.byte_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      g = rnd ? $urandom_range(0, gap) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int c0);
    int n = 0;
    while (done_cnt == c0 && n < 40) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (done_cnt == c0) begin
      miscompares++;
      $display("FAIL done_timeout done_cnt=%0d required>%0d", done_cnt, c0);
    end
  endtask

  task automatic clear_obs();
    im_q.delete(); dm_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.target = 0; bus.base_addr = 0; bus.word_count = 0;
    bus.byte_valid = 0; bus.byte_data = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    vectors++;
    if ({bus.IMLD, bus.DMLD, bus.IMWD, bus.IMA, bus.DMWD, bus.DMA, bus.byte_ready,
         bus.busy, bus.done, bus.error} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs IMA=%h IMWD=%h DMA=%h DMWD=%h rdy=%b busy=%b done=%b err=%b required all 0",
               bus.IMA, bus.IMWD, bus.DMA, bus.DMWD, bus.byte_ready, bus.busy, bus.done, bus.error);
    end
    vectors++;
    if (bus.core_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_core_rst got=%b required=1", bus.core_rst);
    end
  endtask

  task automatic test_imem_b2b(input int gap, input string name);
    int c0 = done_cnt, rv0 = ready_viol, v0 = viol;
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_exp(32'h0, 2);
    clear_obs();
    do_start(1'b0, 32'h0, 16'd2);
    vectors++;
    if ({bus.busy, bus.byte_ready, bus.core_rst} !== 3'b111) begin
      miscompares++;
      $display("FAIL %s_after_start busy/rdy/core_rst=%b required=111", name,
               {bus.busy, bus.byte_ready, bus.core_rst});
    end
    send_range(0, 8, gap, 1'b0);
    wait_done(c0);
    vectors++;
    if (bus.core_rst !== 1'b0) begin
      miscompares++; $display("FAIL %s_core_rst got=%b required=0", name, bus.core_rst);
    end
    repeat (4) @(posedge clk); #1;
    vectors++;
    if (done_cnt - c0 !== 1) begin
      miscompares++; $display("FAIL %s_done_pulses got=%0d required=1", name, done_cnt - c0);
    end
    vectors++;
    if (im_q.size() !== 2 || dm_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_strobe_count im=%0d dm=%0d required im=2 dm=0", name, im_q.size(), dm_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (im_q[i].a !== exp_q[i].a || im_q[i].d !== exp_q[i].d) begin
          miscompares++;
          $display("FAIL %s_word%0d IMA=%h IMWD=%h required IMA=%h IMWD=%h", name, i,
                   im_q[i].a, im_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
    end
    vectors++;
    if (viol != v0 || ready_viol != rv0) begin
      miscompares++;
      $display("FAIL %s_protocol strobe_viol=%0d ready_viol=%0d required 0", name,
               viol - v0, ready_viol - rv0);
    end
  endtask

  task automatic test_dmem();
    int c0 = done_cnt;
    img = '{8'h01, 8'h00, 8'h00, 8'h00};
    build_exp(32'h100, 1);
    clear_obs();
    do_start(1'b1, 32'h100, 16'd1);
    send_range(0, 4, 0, 1'b0);
    wait_done(c0);
    vectors++;
    if (dm_q.size() !== 1 || im_q.size() !== 0) begin
      miscompares++;
      $display("FAIL dmem_strobe_count dm=%0d im=%0d required dm=1 im=0", dm_q.size(), im_q.size());
    end else begin
      vectors++;
      if (dm_q[0].a !== exp_q[0].a || dm_q[0].d !== exp_q[0].d) begin
        miscompares++;
        $display("FAIL dmem_word DMA=%h DMWD=%h required DMA=%h DMWD=%h",
                 dm_q[0].a, dm_q[0].d, exp_q[0].a, exp_q[0].d);
      end
    end
    vectors++;
    if (bus.IMA !== 32'h4 || bus.IMWD !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL imem_hold IMA=%h IMWD=%h required IMA=00000004 IMWD=deadbeef", bus.IMA, bus.IMWD);
    end
  endtask

  task automatic test_bad_count();
    int c0;
    pulse_rst();
    clear_obs();
    do_start(1'b0, 32'h0, 16'd0);
    vectors++;
    if ({bus.error, bus.busy, bus.core_rst, bus.byte_ready} !== 4'b1010) begin
      miscompares++;
      $display("FAIL count_zero err/busy/core_rst/rdy=%b required=1010",
               {bus.error, bus.busy, bus.core_rst, bus.byte_ready});
    end
    do_start(1'b0, 32'h0, 16'd65);
    repeat (5) @(posedge clk); #1;
    vectors++;
    if ({bus.error, bus.busy, bus.core_rst} !== 3'b101 || im_q.size() + dm_q.size() != 0) begin
      miscompares++;
      $display("FAIL count_over err/busy/core_rst=%b strobes=%0d required=101 strobes=0",
               {bus.error, bus.busy, bus.core_rst}, im_q.size() + dm_q.size());
    end
    img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    build_exp(32'h20, 1);
    c0 = done_cnt;
    do_start(1'b1, 32'h20, 16'd1);
    vectors++;
    if (bus.error !== 1'b0) begin
      miscompares++; $display("FAIL error_clear got=%b required=0", bus.error);
    end
    send_range(0, 4, 0, 1'b0);
    wait_done(c0);
    vectors++;
    if (dm_q.size() !== 1 || dm_q[0].a !== exp_q[0].a || dm_q[0].d !== exp_q[0].d) begin
      miscompares++;
      $display("FAIL after_error_load dm_count=%0d required 1 with DMA=%h DMWD=%h",
               dm_q.size(), exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_reset_midload();
    int c0;
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_obs();
    do_start(1'b0, 32'h40, 16'd1);
    send_range(0, 2, 0, 1'b0);
    pulse_rst();
    repeat (3) @(posedge clk); #1;
    vectors++;
    if ({bus.busy, bus.byte_ready, bus.core_rst} !== 3'b001 || im_q.size() + dm_q.size() != 0) begin
      miscompares++;
      $display("FAIL midload_rst busy/rdy/core_rst=%b strobes=%0d required=001 strobes=0",
               {bus.busy, bus.byte_ready, bus.core_rst}, im_q.size() + dm_q.size());
    end
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    build_exp(32'h80, 1);
    c0 = done_cnt;
    do_start(1'b0, 32'h80, 16'd1);
    send_range(0, 4, 0, 1'b0);
    wait_done(c0);
    vectors++;
    if (im_q.size() !== 1 || im_q[0].a !== exp_q[0].a || im_q[0].d !== exp_q[0].d) begin
      miscompares++;
      $display("FAIL fresh_load im_count=%0d required 1 with IMA=%h IMWD=%h",
               im_q.size(), exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_start_during_recv();
    int c0 = done_cnt;
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    build_exp(32'h200, 2);
    clear_obs();
    do_start(1'b0, 32'h200, 16'd2);
    send_range(0, 2, 0, 1'b0);
    do_start(1'b1, 32'h999, 16'd3);
    send_range(2, 8, 0, 1'b0);
    wait_done(c0);
    repeat (10) @(posedge clk); #1;
    vectors++;
    if (im_q.size() !== 2 || dm_q.size() !== 0 || done_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL start_in_recv im=%0d dm=%0d done=%0d required im=2 dm=0 done=1",
               im_q.size(), dm_q.size(), done_cnt - c0);
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (im_q[i] != exp_q[i]) begin
          miscompares++;
          $display("FAIL start_in_recv_word%0d IMA=%h IMWD=%h required IMA=%h IMWD=%h", i,
                   im_q[i].a, im_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
    end
  endtask

  task automatic test_random();
    logic t;
    logic [31:0] base;
    int cnt, c0;
    for (int it = 0; it < 6; it++) begin
      t    = 1'($urandom);
      base = (it == 0) ? 32'hFFFF_FFF8 : $urandom;
      cnt  = (it == 1) ? 64 : $urandom_range(1, 6);
      img.delete();
      for (int i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom));
      build_exp(base, cnt);
      clear_obs();
      c0 = done_cnt;
      do_start(t, base, 16'(cnt));
      send_range(0, 4 * cnt, 2, 1'b1);
      wait_done(c0);
      vectors++;
      if ((t ? dm_q.size() : im_q.size()) !== cnt || (t ? im_q.size() : dm_q.size()) !== 0) begin
        miscompares++;
        $display("FAIL rand%0d_count im=%0d dm=%0d required %0d on target %0d",
                 it, im_q.size(), dm_q.size(), cnt, t);
      end else begin
        foreach (exp_q[i]) begin
          vectors++;
          if ((t ? dm_q[i] : im_q[i]) != exp_q[i]) begin
            miscompares++;
            $display("FAIL rand%0d_word%0d got a=%h d=%h required a=%h d=%h", it, i,
                     t ? dm_q[i].a : im_q[i].a, t ? dm_q[i].d : im_q[i].d, exp_q[i].a, exp_q[i].d);
          end
        end
      end
      vectors++;
      if (bus.core_rst !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_status core_rst=%b busy=%b required 0 0", it, bus.core_rst, bus.busy);
      end
    end
    vectors++;
    if (viol != 0) begin
      miscompares++; $display("FAIL strobe_spacing violations=%0d required=0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_imem_b2b(0, "b2b");
    test_imem_b2b(3, "gaps");
    test_dmem();
    test_bad_count();
    test_reset_midload();
    test_start_during_recv();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
